// File: rtl/window_counter_mc.sv
// window_counter_mc: per-channel sliding-window event counter built from a ring of fixed-length bins.
// Optional per-channel threshold compare (threshold/above ports) is built when WINDOW_COUNTER_MC_THRESH_EN is defined.
module window_counter_mc #(
  parameter int CLK_FREQ_HZ    = 27_000_000,
  parameter int SAMPLE_TIME_MS = 10,
  parameter int SAMPLE_COUNT   = 100,
  parameter int NUM_CHANNELS   = 4,
  parameter int MAX_VALUE      = 4000,
  parameter int EDGE_MODE      = 0,
  localparam int SAMPLE_PERIOD = (CLK_FREQ_HZ/1000)*SAMPLE_TIME_MS,
  localparam int BIN_WIDTH     = $clog2(MAX_VALUE/SAMPLE_COUNT+1),
  localparam int COUNTER_WIDTH = $clog2(SAMPLE_COUNT*(2**BIN_WIDTH-1)+1)
) (
  input  logic                                  sys_clk,
  input  logic                                  reset,
  input  logic [NUM_CHANNELS-1:0]               enable,
  input  logic                                  clear,
`ifdef WINDOW_COUNTER_MC_THRESH_EN
  input  logic [COUNTER_WIDTH-1:0]              threshold,
  output logic [NUM_CHANNELS-1:0]               above,
`endif
  output logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] counter,
  output logic                                  valid,
  output logic                                  updated,
  output logic [NUM_CHANNELS-1:0]               overflow
);

  localparam int TICK_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int IDX_W  = $clog2(SAMPLE_COUNT);
  localparam logic [TICK_W-1:0]    TICK_LAST = TICK_W'(SAMPLE_PERIOD-1);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(SAMPLE_COUNT-1);
  localparam logic [BIN_WIDTH-1:0] BIN_MAX   = '1;

  logic [TICK_W-1:0]       tick;
  logic [IDX_W-1:0]        idx;
  logic [NUM_CHANNELS-1:0] enable_q;
  logic [NUM_CHANNELS-1:0] evt;
  logic [NUM_CHANNELS-1:0] sat_hit;
  logic                    sample_end;
  logic [BIN_WIDTH-1:0]    bin      [NUM_CHANNELS];
  logic [BIN_WIDTH-1:0]    bin_nxt  [NUM_CHANNELS];
  logic [BIN_WIDTH-1:0]    ring     [SAMPLE_COUNT][NUM_CHANNELS];
  logic [COUNTER_WIDTH-1:0] sum_nxt [NUM_CHANNELS];

  function automatic logic [BIN_WIDTH-1:0] sat_inc(input logic [BIN_WIDTH-1:0] b,
                                                   input logic e);
    if (e && (b != BIN_MAX))
      return b + 1'b1;
    return b;
  endfunction

  // Drop the bin leaving the window and add the one entering it; one spare bit absorbs the
  // transient of subtract-then-add, the true result always fits COUNTER_WIDTH.
  function automatic logic [COUNTER_WIDTH-1:0] window_sum(input logic [COUNTER_WIDTH-1:0] cur,
                                                          input logic [BIN_WIDTH-1:0] oldest,
                                                          input logic [BIN_WIDTH-1:0] newest);
    logic [COUNTER_WIDTH:0] acc;
    logic [COUNTER_WIDTH:0] o;
    logic [COUNTER_WIDTH:0] w;
    o = '0;
    w = '0;
    o[BIN_WIDTH-1:0] = oldest;
    w[BIN_WIDTH-1:0] = newest;
    acc = {1'b0, cur} - o + w;
    return COUNTER_WIDTH'(acc);
  endfunction

  always_comb begin
    sample_end = (tick == TICK_LAST);
    evt        = (EDGE_MODE != 0) ? (enable & ~enable_q) : enable;
    for (int n = 0; n < NUM_CHANNELS; n++) begin
      bin_nxt[n] = sat_inc(bin[n], evt[n]);
      sat_hit[n] = evt[n] & (bin[n] == BIN_MAX);
      sum_nxt[n] = window_sum(counter[n*COUNTER_WIDTH +: COUNTER_WIDTH], ring[idx][n], bin_nxt[n]);
    end
  end

  // Single register stage: bins accumulate every cycle, window sum commits on sample_end.
  always_ff @(posedge sys_clk) begin
    if (reset || clear) begin
      tick     <= '0;
      idx      <= '0;
      enable_q <= '0;
      counter  <= '0;
      valid    <= 1'b0;
      updated  <= 1'b0;
      overflow <= '0;
`ifdef WINDOW_COUNTER_MC_THRESH_EN
      above    <= '0;
`endif
      for (int n = 0; n < NUM_CHANNELS; n++)
        bin[n] <= '0;
      for (int s = 0; s < SAMPLE_COUNT; s++)
        for (int n = 0; n < NUM_CHANNELS; n++)
          ring[s][n] <= '0;
    end else begin
      enable_q <= enable;
      updated  <= sample_end;
      overflow <= overflow | sat_hit;
      tick     <= sample_end ? '0 : tick + 1'b1;
      for (int n = 0; n < NUM_CHANNELS; n++)
        bin[n] <= sample_end ? '0 : bin_nxt[n];
      if (sample_end) begin
        for (int n = 0; n < NUM_CHANNELS; n++) begin
          ring[idx][n]                             <= bin_nxt[n];
          counter[n*COUNTER_WIDTH +: COUNTER_WIDTH] <= sum_nxt[n];
`ifdef WINDOW_COUNTER_MC_THRESH_EN
          above[n]                                 <= (sum_nxt[n] >= threshold);
`endif
        end
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        if (idx == IDX_LAST)
          valid <= 1'b1;
      end
    end
  end

endmodule
